prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of data words, PC and instruction.
REQ-002 SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-003 SHALL have parameter NUM_TGT, default 3, number of load targets (0=regfile, 1=data mem, 2=instr mem).
REQ-004 SHALL have parameter TRACE_DEPTH, default 16, trace FIFO depth, power of 2, >=2.
REQ-005 SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF, instruction encoding that ends a run.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1, synchronous, active-low.
REQ-007 SHALL have ports: start in 1, begin session; run_cycles in 16, cycle limit (0 = unlimited).
REQ-008 SHALL have load-stream ports: ld_valid in 1; ld_ready out 1; ld_tgt in clog2(NUM_TGT); ld_addr in ADDR_W; ld_data in DATA_W; ld_last in 1.
REQ-009 SHALL have write ports: wr_en out NUM_TGT, one-hot; wr_addr out ADDR_W; wr_data out DATA_W.
REQ-010 SHALL have processor ports: cpu_rst_n out 1; pc_in in DATA_W; instr_in in DATA_W.
REQ-011 SHALL have trace ports: tr_valid out 1; tr_ready in 1; tr_pc out DATA_W; tr_instr out DATA_W.
REQ-012 SHALL have status ports: busy out 1; done out 1; timeout out 1; tgt_err out 1; ovf_cnt out 8.

Function
REQ-013 SHALL implement states IDLE, LOAD, RELEASE, RUN, DRAIN, DONE.
REQ-014 SHALL move IDLE->LOAD and DONE->LOAD on start=1; start SHALL be ignored in other states.
REQ-015 SHALL assert ld_ready only in LOAD; a beat transfers when ld_valid and ld_ready are both 1.
REQ-016 SHALL, one cycle after a transfer with ld_tgt<NUM_TGT, pulse wr_en[ld_tgt] for one cycle with registered wr_addr/wr_data.
REQ-017 SHALL consume beats with ld_tgt>=NUM_TGT without writing and set sticky tgt_err.
REQ-018 SHALL move LOAD->RELEASE on the transfer carrying ld_last=1, after which ld_ready SHALL be 0.
REQ-019 SHALL hold RELEASE exactly one cycle with cpu_rst_n=0, then enter RUN with cpu_rst_n=1.
REQ-020 SHALL, in each RUN cycle, push {pc_in, instr_in} into the trace FIFO; when the FIFO is full without a same-cycle pop, it SHALL drop the entry and increment ovf_cnt, saturating at 255.
REQ-021 SHALL count RUN cycles from 0; when instr_in==HALT_INSTR, it SHALL push that entry and enter DRAIN.
REQ-022 SHALL, when run_cycles!=0 and the count reaches run_cycles-1 without halt, set timeout and enter DRAIN; halt SHALL take priority on the same cycle.
REQ-023 SHALL drive cpu_rst_n=0 in every state except RUN.
REQ-024 SHALL move DRAIN->DONE when the FIFO is empty; done SHALL be 1 only in DONE.
REQ-025 SHALL hold tr_valid=1 while the FIFO is non-empty and pop it on tr_valid&&tr_ready, in any state.
REQ-026 SHALL make the FIFO first-word-fall-through and accept a push when full if a pop occurs in the same cycle.
REQ-027 SHALL drive busy=1 in LOAD, RELEASE, RUN and DRAIN.
REQ-028 SHALL clear timeout, tgt_err, ovf_cnt and the cycle count on entry to LOAD.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, enter IDLE with cpu_rst_n=0, ld_ready=0, wr_en=0, tr_valid=0, busy=0, done=0, timeout=0, tgt_err=0, ovf_cnt=0, the FIFO empty and the cycle count 0.
REQ-030 SHALL honour reset in any state, including mid-LOAD and mid-RUN, discarding in-flight writes and trace data.

Structure
REQ-031 SHALL place the state enum, target index constants (TGT_REG, TGT_DM, TGT_IM) and the default HALT_INSTR in shared package prog_load_pkg.
REQ-032 SHALL implement the trace buffer as sub-module trace_fifo, parametrised by width and depth.

Verification
REQ-033 SHALL cover this case: reset, start, then 3 beats (tgt 2 addr 0 data 0x2001_0005; tgt 1 addr 4 data 0xAB; tgt 0 addr 1 data 7, last) -> wr_en 100, 010, 001 one cycle after each beat, then RELEASE, then cpu_rst_n=1.
REQ-034 SHALL cover this case: in RUN, pc_in 0,4,8 with instr_in=HALT_INSTR at pc 8, tr_ready=1 -> trace pc 0,4,8, then DONE, done=1, timeout=0.
REQ-035 SHALL cover this case: run_cycles=5 with no halt -> exactly 5 entries pushed, timeout=1, then DONE.
REQ-036 SHALL cover this case: TRACE_DEPTH=4, tr_ready=0, 10 RUN cycles then halt -> ovf_cnt=7 (11 pushes, 4 kept), 4 entries drained in order once tr_ready=1.
REQ-037 SHALL cover this case: beat with ld_tgt=3 -> no wr_en and tgt_err=1; a reset pulse mid-RUN -> IDLE with all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/prog_load_pkg.sv
// prog_load_pkg: shared types and constants for the program-load controller
package prog_load_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;
    localparam int TGT_REG = 0;
    localparam int TGT_DM = 1;
    localparam int TGT_IM = 2;
    localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
endpackage

// File: rtl/prog_load_ctrl_trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO that accepts a push when full if a pop happens in the same cycle
module trace_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         accept,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic full, do_pop;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop = pop && !empty;
    assign accept = push && (!full || do_pop);
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= wp + ONE;
            if (do_pop) rp <= rp + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: streams a program into target memories, releases the CPU, traces its run and drains the trace
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NUM_TGT = 3,
    parameter int TRACE_DEPTH = 16,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(DEF_HALT_INSTR),
    localparam int TW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       run_cycles,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [TW-1:0]     ld_tgt,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [NUM_TGT-1:0] wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst_n,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [DATA_W-1:0] tr_pc,
    output logic [DATA_W-1:0] tr_instr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              tgt_err,
    output logic [7:0]        ovf_cnt
);
    state_t state, state_nxt;
    logic [15:0] cyc_cnt;
    logic xfer, tgt_ok, enter_load, in_run, halt, tmo_hit, accept, empty;
    logic [2*DATA_W-1:0] dout;
    assign xfer = ld_valid && ld_ready;
    assign tgt_ok = 32'(ld_tgt) < NUM_TGT;
    assign enter_load = (state == S_IDLE || state == S_DONE) && start;
    assign in_run = state == S_RUN;
    assign halt = in_run && instr_in == HALT_INSTR;
    // halt wins over the cycle limit when both land on the same cycle
    assign tmo_hit = in_run && !halt && run_cycles != 16'd0 && cyc_cnt == run_cycles - 16'd1;
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:    state_nxt = (xfer && ld_last) ? S_RELEASE : S_LOAD;
            S_RELEASE: state_nxt = S_RUN;
            S_RUN:     state_nxt = (halt || tmo_hit) ? S_DRAIN : S_RUN;
            S_DRAIN:   state_nxt = empty ? S_DONE : S_DRAIN;
            S_DONE:    state_nxt = start ? S_LOAD : S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        ld_ready = state == S_LOAD;
        cpu_rst_n = in_run;
        busy = state inside {S_LOAD, S_RELEASE, S_RUN, S_DRAIN};
        done = state == S_DONE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            timeout <= 1'b0;
            tgt_err <= 1'b0;
            ovf_cnt <= 8'd0;
            cyc_cnt <= 16'd0;
        end else if (enter_load) begin
            wr_en <= '0;
            timeout <= 1'b0;
            tgt_err <= 1'b0;
            ovf_cnt <= 8'd0;
            cyc_cnt <= 16'd0;
        end else begin
            wr_en <= (xfer && tgt_ok) ? NUM_TGT'(1) << ld_tgt : '0;
            if (xfer) begin
                wr_addr <= ld_addr;
                wr_data <= ld_data;
            end
            if (xfer && !tgt_ok) tgt_err <= 1'b1;
            if (in_run) cyc_cnt <= cyc_cnt + 16'd1;
            if (tmo_hit) timeout <= 1'b1;
            if (in_run && !accept && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
    trace_fifo #(
        .W(2 * DATA_W),
        .DEPTH(TRACE_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(in_run),
        .din({pc_in, instr_in}),
        .accept(accept),
        .pop(tr_ready),
        .empty(empty),
        .dout(dout)
    );
    assign tr_valid = !empty;
    assign tr_pc = dout[2*DATA_W-1:DATA_W];
    assign tr_instr = dout[DATA_W-1:0];
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed self-checking bench for prog_load_ctrl with a 4-deep trace FIFO
module tb_prog_load_ctrl;
    import prog_load_pkg::*;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    logic clk = 1'b0;
    logic reset, start, ld_valid, ld_ready, ld_last, cpu_rst_n, tr_valid, tr_ready;
    logic busy, done, timeout, tgt_err;
    logic [15:0] run_cycles;
    logic [1:0] ld_tgt;
    logic [7:0] ld_addr, wr_addr, ovf_cnt;
    logic [31:0] ld_data, wr_data, pc_in, instr_in, tr_pc, tr_instr;
    logic [2:0] wr_en;
    int n_chk = 0, n_fail = 0, seen;
    always #5 clk = ~clk;
    prog_load_ctrl #(
        .TRACE_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tgt(ld_tgt), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_rst_n(cpu_rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
        .busy(busy), .done(done), .timeout(timeout), .tgt_err(tgt_err), .ovf_cnt(ovf_cnt)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_tr_valid"}, tr_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_tgt_err"}, tgt_err, 0);
        check({tag, "_ovf_cnt"}, ovf_cnt, 0);
    endtask
    task automatic beat(input logic [1:0] t, input logic [7:0] a, input logic [31:0] d, input logic l);
        ld_valid = 1'b1;
        ld_tgt = t;
        ld_addr = a;
        ld_data = d;
        ld_last = l;
        tick();
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask
    task automatic wait_done(input string tag);
        for (int i = 0; i < 30 && !done; i++) tick();
        check(tag, done, 1);
    endtask
    initial begin
        reset = 1'b0;
        start = 1'b0;
        run_cycles = 16'd0;
        ld_valid = 1'b0;
        ld_tgt = '0;
        ld_addr = '0;
        ld_data = '0;
        ld_last = 1'b0;
        pc_in = '0;
        instr_in = '0;
        tr_ready = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        // load three beats, one per target
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready", ld_ready, 1);
        check("load_busy", busy, 1);
        beat(2'(TGT_IM), 8'd0, 32'h2001_0005, 1'b0);
        check("b1_wr_en", wr_en, 3'b100);
        check("b1_wr_addr", wr_addr, 0);
        check("b1_wr_data", wr_data, 32'h2001_0005);
        beat(2'(TGT_DM), 8'd4, 32'hAB, 1'b0);
        check("b2_wr_en", wr_en, 3'b010);
        check("b2_wr_addr", wr_addr, 4);
        check("b2_wr_data", wr_data, 32'hAB);
        beat(2'(TGT_REG), 8'd1, 32'd7, 1'b1);
        check("b3_wr_en", wr_en, 3'b001);
        check("b3_wr_data", wr_data, 7);
        check("rel_ld_ready", ld_ready, 0);
        check("rel_cpu_rst_n", cpu_rst_n, 0);
        check("rel_busy", busy, 1);
        tick();
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_wr_en", wr_en, 0);
        // run with halt at pc 8
        pc_in = 32'd0;
        instr_in = 32'h13;
        tick();
        check("h_v0", tr_valid, 1);
        check("h_pc0", tr_pc, 0);
        check("h_in0", tr_instr, 32'h13);
        pc_in = 32'd4;
        tick();
        check("h_pc4", tr_pc, 4);
        pc_in = 32'd8;
        instr_in = HALT;
        tick();
        check("h_pc8", tr_pc, 8);
        check("h_halt_instr", tr_instr, HALT);
        check("drain_cpu_rst_n", cpu_rst_n, 0);
        check("drain_busy", busy, 1);
        instr_in = 32'h0;
        wait_done("h_done");
        check("h_timeout", timeout, 0);
        check("h_busy", busy, 0);
        check("h_tr_valid", tr_valid, 0);
        // cycle limit of 5 without halt
        run_cycles = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t_done_clr", done, 0);
        beat(2'(TGT_REG), 8'd2, 32'd1, 1'b1);
        tick();
        check("t_run", cpu_rst_n, 1);
        seen = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            pc_in = 32'(k * 4);
            tick();
            if (tr_valid) begin
                check("t_pc", tr_pc, 64'(seen * 4));
                seen++;
            end
        end
        check("t_entries", 64'(seen), 5);
        check("t_timeout", timeout, 1);
        check("t_done", done, 1);
        // bad target, then overflow with a stalled consumer
        run_cycles = 16'd0;
        tr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("o_timeout_clr", timeout, 0);
        beat(2'd3, 8'd5, 32'd9, 1'b0);
        check("o_bad_wr_en", wr_en, 0);
        check("o_tgt_err", tgt_err, 1);
        beat(2'(TGT_DM), 8'd6, 32'd3, 1'b1);
        check("o_good_wr_en", wr_en, 3'b010);
        tick();
        for (int k = 0; k < 11; k++) begin
            pc_in = 32'(k * 4);
            instr_in = (k == 10) ? HALT : 32'h0;
            tick();
        end
        instr_in = 32'h0;
        check("o_ovf_cnt", ovf_cnt, 7);
        check("o_tgt_err_sticky", tgt_err, 1);
        check("o_not_done", done, 0);
        tr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("o_valid", tr_valid, 1);
            check("o_pc", tr_pc, 64'(i * 4));
            tick();
        end
        wait_done("o_done");
        check("o_empty", tr_valid, 0);
        check("o_ovf_hold", ovf_cnt, 7);
        // reset pulse in the middle of RUN
        tr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r_tgt_err_clr", tgt_err, 0);
        check("r_ovf_clr", ovf_cnt, 0);
        beat(2'(TGT_REG), 8'd0, 32'd5, 1'b1);
        tick();
        tick();
        tick();
        check("r_in_run", cpu_rst_n, 1);
        check("r_fifo_filled", tr_valid, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_outputs("mid_run");
        tick();
        check("r_idle_ready", ld_ready, 0);
        check("r_idle_valid", tr_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
